// File: rtl/multi_channel_percent_calc_pkg.sv
// multi_channel_percent_calc_pkg: shared FSM states and numerator width helper
package multi_channel_percent_calc_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, DIVIDE, STORE, DONE} state_t;
  function automatic int num_width(input int dw, input int scale);
    return dw + $clog2(scale) + 1;
  endfunction
endpackage

// File: rtl/percent_div_core.sv
// percent_div_core: serial restoring divider, one quotient bit per cycle
module percent_div_core #(
  parameter int DW = 21,
  parameter int NW = 29
) (
  input  logic          CLK100MHZ,
  input  logic          reset,
  input  logic          load,
  input  logic [NW-1:0] num,
  input  logic [DW-1:0] den,
  output logic          valid,
  output logic [NW-1:0] quo
);
  localparam int CW = $clog2(NW + 1);
  logic [DW-1:0] rem_q, rem_d, den_q, den_d, dsel, rsrc;
  logic [NW-1:0] n_q, n_d, nsrc;
  logic [CW-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d, ge, step;
  logic [DW:0] t;
  // the first quotient bit is produced on the load edge itself, so NW-1 steps remain
  always_comb begin
    dsel = load ? den : den_q;
    rsrc = load ? '0 : rem_q;
    nsrc = load ? num : n_q;
    t = {rsrc, nsrc[NW-1]};
    ge = t >= {1'b0, dsel};
    step = load || cnt_q != '0;
    rem_d = step ? (ge ? DW'(t - {1'b0, dsel}) : t[DW-1:0]) : rem_q;
    n_d = step ? {nsrc[NW-2:0], ge} : n_q;
    den_d = dsel;
    cnt_d = load ? CW'(NW - 1) : (cnt_q != '0 ? cnt_q - CW'(1) : cnt_q);
    valid_d = load ? (NW == 1) : (valid_q || cnt_q == CW'(1));
  end
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      rem_q <= '0;
      den_q <= '0;
      n_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      den_q <= den_d;
      n_q <= n_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
    end
  end
  assign valid = valid_q;
  assign quo = n_q;
endmodule

// File: rtl/multi_channel_percent_calc.sv
// multi_channel_percent_calc: per-channel rounded ratio dividend*SCALE/divisor,
// channels sequenced through one shared serial divider
module multi_channel_percent_calc
  import multi_channel_percent_calc_pkg::*;
#(
  parameter int DW = 21,
  parameter int NCH = 3,
  parameter int PW = 10,
  parameter int SCALE = 100
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              start,
  input  logic [NCH*DW-1:0] dividend,
  input  logic [DW-1:0]     divisor,
  output logic              busy,
  output logic              done,
  output logic [NCH*PW-1:0] percentage,
  output logic              div_zero,
  output logic [NCH-1:0]    sat
);
  localparam int NW = num_width(DW, SCALE);
  localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
  localparam logic [NW-1:0] QMAX = NW'((64'd1 << PW) - 64'd1);
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NCH*DW-1:0] div_q, div_d;
  logic [DW-1:0] den_q, den_d, ch;
  logic [NCH*PW-1:0] res_q, res_d, pct_q, pct_d;
  logic [NCH-1:0] rsat_q, rsat_d, sat_q, sat_d;
  logic dz_q, dz_d, dzo_q, dzo_d, busy_q, busy_d, done_q, done_d;
  logic core_load, core_valid, qsat;
  logic [NW-1:0] num, quo;
  percent_div_core #(.DW(DW), .NW(NW)) u_core (
    .CLK100MHZ(CLK100MHZ),
    .reset(reset),
    .load(core_load),
    .num(num),
    .den(den_q),
    .valid(core_valid),
    .quo(quo)
  );
  always_comb begin
    ch = div_q[idx_q*DW +: DW];
    num = NW'(ch) * NW'(SCALE) + NW'(den_q >> 1);
    qsat = quo > QMAX;
    state_d = state_q;
    idx_d = idx_q;
    div_d = div_q;
    den_d = den_q;
    res_d = res_q;
    rsat_d = rsat_q;
    dz_d = dz_q;
    pct_d = pct_q;
    sat_d = sat_q;
    dzo_d = dzo_q;
    busy_d = busy_q;
    done_d = 1'b0;
    core_load = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        div_d = dividend;
        den_d = divisor;
        idx_d = '0;
        dz_d = divisor == '0;
        busy_d = divisor != '0;
        state_d = divisor == '0 ? DONE : LOAD;
      end
      LOAD: begin
        core_load = 1'b1;
        state_d = DIVIDE;
      end
      DIVIDE: state_d = core_valid ? STORE : DIVIDE;
      STORE: begin
        res_d[idx_q*PW +: PW] = qsat ? PW'(QMAX) : quo[PW-1:0];
        rsat_d[idx_q] = qsat;
        idx_d = idx_q == IW'(NCH - 1) ? idx_q : idx_q + IW'(1);
        busy_d = idx_q != IW'(NCH - 1);
        state_d = idx_q == IW'(NCH - 1) ? DONE : LOAD;
      end
      DONE: begin
        pct_d = dz_q ? '0 : res_q;
        sat_d = dz_q ? '0 : rsat_q;
        dzo_d = dz_q;
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      div_q <= '0;
      den_q <= '0;
      res_q <= '0;
      rsat_q <= '0;
      dz_q <= 1'b0;
      pct_q <= '0;
      sat_q <= '0;
      dzo_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      div_q <= div_d;
      den_q <= den_d;
      res_q <= res_d;
      rsat_q <= rsat_d;
      dz_q <= dz_d;
      pct_q <= pct_d;
      sat_q <= sat_d;
      dzo_q <= dzo_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign percentage = pct_q;
  assign div_zero = dzo_q;
  assign sat = sat_q;
endmodule

// File: tb/tb_multi_channel_percent_calc.sv
// tb_multi_channel_percent_calc: latency-level reference model checked every cycle,
// plus directed jobs with hand-computed results
module tb_multi_channel_percent_calc;
  localparam int DW = 21, NCH = 3, PW = 10, SCALE = 100, LAT = 94;
  logic CLK100MHZ = 1'b0, reset = 1'b1, start = 1'b0;
  logic [NCH*DW-1:0] dividend = '0;
  logic [DW-1:0] divisor = '0;
  logic busy, done, div_zero;
  logic [NCH*PW-1:0] percentage;
  logic [NCH-1:0] sat;
  int checks = 0, failures = 0;
  bit chk_en = 0;

  multi_channel_percent_calc #(.DW(DW), .NCH(NCH), .PW(PW), .SCALE(SCALE)) dut (
    .CLK100MHZ(CLK100MHZ),
    .reset(reset),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .percentage(percentage),
    .div_zero(div_zero),
    .sat(sat)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // model: a job is accepted when idle, results appear LAT (or 1) cycles later
  logic m_busy, m_done, m_dz, p_dz;
  logic [NCH*PW-1:0] m_pct, p_pct;
  logic [NCH-1:0] m_sat, p_sat;
  int m_left;
  always @(posedge CLK100MHZ) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_dz = 0; m_pct = '0; m_sat = '0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 1 && !p_dz) m_busy = 0;
        if (m_left == 0) begin
          m_done = 1; m_pct = p_pct; m_sat = p_sat; m_dz = p_dz;
        end
      end else if (start) begin
        p_dz = divisor == '0;
        p_pct = '0;
        p_sat = '0;
        if (!p_dz)
          for (int i = 0; i < NCH; i++) begin
            longint d, q;
            d = longint'(dividend[i*DW +: DW]);
            q = (d * SCALE + longint'(divisor) / 2) / longint'(divisor);
            p_sat[i] = q > 1023;
            p_pct[i*PW +: PW] = q > 1023 ? 10'd1023 : PW'(q);
          end
        m_left = p_dz ? 1 : LAT;
        m_busy = !p_dz;
      end
    end
  end

  always @(negedge CLK100MHZ) begin
    if (chk_en) begin
      chk("cyc_busy", busy, m_busy);
      chk("cyc_done", done, m_done);
      chk("cyc_pct", percentage, m_pct);
      chk("cyc_sat", sat, m_sat);
      chk("cyc_dz", div_zero, m_dz);
    end
  end

  task automatic run(input logic [NCH*DW-1:0] dv, input logic [DW-1:0] ds, input int lat,
                     input logic [NCH*PW-1:0] ep, input logic [NCH-1:0] es, input logic ez,
                     input int rp);
    int n, bc;
    dividend = dv; divisor = ds; start = 1;
    @(negedge CLK100MHZ);
    start = 0;
    n = 0; bc = 0;
    while (!done && n < 200) begin
      if (busy) bc++;
      @(negedge CLK100MHZ);
      n++;
      if (n == rp) begin
        dividend = ~dv; divisor = ds + 5; start = 1;
      end else start = 0;
    end
    start = 0;
    chk("job_latency", n, lat);
    chk("job_busy_cycles", bc, lat == 1 ? 0 : lat - 1);
    chk("job_pct", percentage, ep);
    chk("job_sat", sat, es);
    chk("job_dz", div_zero, ez);
  endtask

  initial begin
    int dn;
    @(negedge CLK100MHZ);
    chk_en = 1;
    @(negedge CLK100MHZ);
    reset = 0;
    chk("rst_busy", busy, 0);
    chk("rst_pct", percentage, 0);
    run({21'd0, 21'd25, 21'd50}, 21'd200, 94, {10'd0, 10'd13, 10'd25}, 3'b000, 1'b0, 0);
    run({21'd3, 21'd2, 21'd1}, 21'd3, 94, {10'd100, 10'd67, 10'd33}, 3'b000, 1'b0, 0);
    run({21'd7, 21'd8, 21'd9}, 21'd0, 1, '0, 3'b000, 1'b1, 0);
    run({21'd7, 21'd5, 21'd20}, 21'd1, 94, {10'd700, 10'd500, 10'd1023}, 3'b001, 1'b0, 0);
    run({21'd1, 21'd1, 21'd1}, 21'd2, 94, {10'd50, 10'd50, 10'd50}, 3'b000, 1'b0, 0);
    run({21'd3, 21'd2, 21'd1}, 21'd3, 94, {10'd100, 10'd67, 10'd33}, 3'b000, 1'b0, 10);
    dividend = {21'd0, 21'd25, 21'd50}; divisor = 21'd200; start = 1;
    @(negedge CLK100MHZ);
    start = 0;
    repeat (39) @(negedge CLK100MHZ);
    reset = 1;
    @(negedge CLK100MHZ);
    reset = 0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_pct", percentage, 0);
    chk("midrst_sat", sat, 0);
    chk("midrst_dz", div_zero, 0);
    dn = 0;
    repeat (100) begin
      @(negedge CLK100MHZ);
      if (done) dn++;
    end
    chk("midrst_no_done", dn, 0);
    run({21'd0, 21'd25, 21'd50}, 21'd200, 94, {10'd0, 10'd13, 10'd25}, 3'b000, 1'b0, 0);
    repeat (3) @(negedge CLK100MHZ);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multi_channel_percent_calc.md
MULTI_CHANNEL_PERCENT_CALC -- requirements
Module: multi_channel_percent_calc

Interface
REQ-001 SHALL have parameter DW, default 21, the width of each dividend and of the divisor.
REQ-002 SHALL have parameter NCH, default 3, the number of channels (e.g. R, G, B).
REQ-003 SHALL have parameter PW, default 10, the width of each percentage result.
REQ-004 SHALL have parameter SCALE, default 100, the result scale (100 for percent, 1000 for per-mille).
REQ-005 SHALL have port CLK100MHZ, input, width 1, the clock; reset is synchronous, active-high, named reset, on clock CLK100MHZ.
REQ-006 SHALL have port reset, input, width 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, width 1, request to compute; sampled only in IDLE.
REQ-008 SHALL have port dividend, input, width NCH*DW, channel i at [i*DW +: DW].
REQ-009 SHALL have port divisor, input, width DW, common total (e.g. clear-channel count).
REQ-010 SHALL have port busy, output, width 1, high while a computation is in progress.
REQ-011 SHALL have port done, output, width 1, one-cycle pulse when results update.
REQ-012 SHALL have port percentage, output, width NCH*PW, channel i at [i*PW +: PW].
REQ-013 SHALL have port div_zero, output, width 1, set when the last job had divisor==0.
REQ-014 SHALL have port sat, output, width NCH, per-channel saturation flag for the last job.

Function
REQ-015 SHALL compute each channel as q = floor((dividend_i*SCALE + floor(divisor/2)) / divisor), i.e. rounded to nearest.
REQ-016 SHALL form the numerator in NW = DW + clog2(SCALE) + 1 bits with no overflow.
REQ-017 SHALL clamp q > 2^PW-1 to 2^PW-1 and set sat[i]; otherwise sat[i]=0.
REQ-018 SHALL implement states IDLE, LOAD, DIVIDE, STORE, DONE.
REQ-019 IDLE with start=1 and divisor!=0: latch dividend and divisor, channel index=0, go to LOAD, busy=1.
REQ-020 IDLE with start=1 and divisor==0: latch, go to DONE; at DONE, percentage=0 for all channels, sat=0, div_zero=1.
REQ-021 LOAD (1 cycle): form the numerator for the current channel; go to DIVIDE.
REQ-022 DIVIDE: restoring shift-subtract, one quotient bit per cycle, for exactly NW cycles; go to STORE.
REQ-023 STORE (1 cycle): write the clamped quotient to an internal result register; if index<NCH-1, increment and go to LOAD, else go to DONE.
REQ-024 DONE (1 cycle): percentage, sat and div_zero update together; done=1; busy=0; go to IDLE.
REQ-025 Latency from the start-sampling edge to done high SHALL be NCH*(NW+2)+1 cycles (94 at defaults), or 1 cycle for divisor==0.
REQ-026 start while busy SHALL be ignored; input changes during busy SHALL have no effect.
REQ-027 Outputs SHALL hold their values between done pulses; a new job SHALL be accepted in the IDLE cycle immediately following DONE.

Reset
REQ-028 reset SHALL force IDLE with busy=0, done=0, percentage=0, div_zero=0, sat=0, and internal registers cleared, taking priority over all other inputs including mid-job.
REQ-029 The first start after reset is released SHALL be processed normally.

Structure
REQ-030 A shared package SHALL hold the state enum and the NW width function.
REQ-031 The serial restoring divider SHALL be one sub-module, percent_div_core (numerator/divisor in, quotient out, with load/valid handshake); the channel sequencing FSM SHALL stay in the top level.

Verification
REQ-032 dividend={0,25,50}, divisor=200 -> ch0=25, ch1=13, ch2=0; done at cycle 94; busy high for 93 cycles.
REQ-033 dividend={3,2,1}, divisor=3 -> ch0=33, ch1=67, ch2=100; sat=0.
REQ-034 divisor=0, any dividend -> done at cycle 1; div_zero=1; all percentages 0.
REQ-035 dividend ch0=20, divisor=1 -> ch0=1023, sat[0]=1; other channels unaffected.
REQ-036 reset asserted at cycle 40 of a job -> next cycle busy=0, all outputs 0, no done pulse; a following job (REQ-032 values) completes correctly.
REQ-037 start re-pulsed at cycle 10 with different inputs -> ignored; results match the first job; exactly one done pulse.
